// File: rtl/modexp_ctrl_if.sv
// modexp_ctrl_if: caller request/result bundle plus Montgomery core handshake.
// Ports: master = caller and core side, slave = modexp_ctrl side.
interface modexp_ctrl_if #(
  parameter int N  = 1024,
  parameter int EW = 1024
);
  logic          start;
  logic [N-1:0]  in_x;
  logic [EW-1:0] in_e;
  logic [N-1:0]  in_m;
  logic [N-1:0]  in_r;
  logic [N-1:0]  in_r2;
  logic [N-1:0]  result;
  logic          done;
  logic          busy;
  logic          mm_start;
  logic [N-1:0]  mm_a;
  logic [N-1:0]  mm_b;
  logic [N-1:0]  mm_m;
  logic [N:0]    mm_result;
  logic          mm_done;

  modport master (
    output start, in_x, in_e, in_m, in_r, in_r2,
    output mm_result, mm_done,
    input  result, done, busy,
    input  mm_start, mm_a, mm_b, mm_m
  );

  modport slave (
    input  start, in_x, in_e, in_m, in_r, in_r2,
    input  mm_result, mm_done,
    output result, done, busy,
    output mm_start, mm_a, mm_b, mm_m
  );
endinterface

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: x^e mod m by square-and-multiply over an external Montgomery core.
// Ports: clk, reset (async, active high), bus (slave): request/result and core handshake.
// Option: define MODEXP_LZ_SKIP_EN to skip leading zero exponent bits.
module modexp_ctrl #(
  parameter int N  = 1024,
  parameter int EW = 1024
) (
  input logic          clk,
  input logic          reset,
  modexp_ctrl_if.slave bus
);
  localparam int IW = (EW > 1) ? $clog2(EW) : 1;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_TM_I = 4'd1;
  localparam logic [3:0] S_TM_W = 4'd2;
  localparam logic [3:0] S_SQ_I = 4'd3;
  localparam logic [3:0] S_SQ_W = 4'd4;
  localparam logic [3:0] S_MU_I = 4'd5;
  localparam logic [3:0] S_MU_W = 4'd6;
  localparam logic [3:0] S_NX   = 4'd7;
  localparam logic [3:0] S_FM_I = 4'd8;
  localparam logic [3:0] S_FM_W = 4'd9;
  localparam logic [3:0] S_DN   = 4'd10;

  logic [3:0]    state_q, state_d;
  logic [N-1:0]  x_q, r2_q, xm_q, acc_q, res_q;
  logic [EW-1:0] e_q;
  logic [IW-1:0] idx_q;
  logic          mm_start_q;
  logic [N-1:0]  mm_a_q, mm_b_q, mm_m_q;
  logic [N-1:0]  op_a, op_b;
  logic          issue, wait_st, cap;
  logic [3:0]    tm_next;
  logic [IW-1:0] tm_idx;
  logic          unused_msb;

  assign unused_msb = bus.mm_result[N];

  assign issue   = state_q inside {S_TM_I, S_SQ_I, S_MU_I, S_FM_I};
  assign wait_st = state_q inside {S_TM_W, S_SQ_W, S_MU_W, S_FM_W};
  // A done coinciding with our own start pulse belongs to an older op.
  assign cap = wait_st & bus.mm_done & ~mm_start_q;

`ifdef MODEXP_LZ_SKIP_EN
  logic [IW-1:0] msb;
  logic          e_nz;

  always_comb begin
    msb  = '0;
    e_nz = 1'b0;
    for (int i = 0; i < EW; i++) begin
      if (e_q[i]) begin
        msb  = IW'(i);
        e_nz = 1'b1;
      end
    end
  end

  // acc = R is a fixed point of squaring, so the top bit goes to MUL.
  assign tm_next = e_nz ? S_MU_I : S_FM_I;
  assign tm_idx  = msb;
`else
  assign tm_next = S_SQ_I;
  assign tm_idx  = IW'(EW - 1);
`endif

  always_comb begin
    op_a = acc_q;
    op_b = acc_q;
    unique case (state_q)
      S_TM_I: begin
        op_a = x_q;
        op_b = r2_q;
      end
      S_MU_I:  op_b = xm_q;
      S_FM_I:  op_b = N'(1);
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_TM_I;
      S_TM_I: state_d = S_TM_W;
      S_TM_W: if (cap) state_d = tm_next;
      S_SQ_I: state_d = S_SQ_W;
      S_SQ_W: if (cap) state_d = e_q[idx_q] ? S_MU_I : S_NX;
      S_MU_I: state_d = S_MU_W;
      S_MU_W: if (cap) state_d = S_NX;
      S_NX:   state_d = (idx_q == '0) ? S_FM_I : S_SQ_I;
      S_FM_I: state_d = S_FM_W;
      S_FM_W: if (cap) state_d = S_DN;
      S_DN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      r2_q       <= '0;
      xm_q       <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      e_q        <= '0;
      idx_q      <= '0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_m_q     <= '0;
    end else begin
      state_q    <= state_d;
      mm_start_q <= 1'b0;
      if (state_q == S_IDLE && bus.start) begin
        x_q    <= bus.in_x;
        e_q    <= bus.in_e;
        r2_q   <= bus.in_r2;
        acc_q  <= bus.in_r;
        mm_m_q <= bus.in_m;
      end
      if (issue) begin
        mm_a_q     <= op_a;
        mm_b_q     <= op_b;
        mm_start_q <= 1'b1;
      end
      if (cap) begin
        unique case (state_q)
          S_TM_W: begin
            xm_q  <= bus.mm_result[N-1:0];
            idx_q <= tm_idx;
          end
          S_SQ_W, S_MU_W: acc_q <= bus.mm_result[N-1:0];
          S_FM_W:  res_q <= bus.mm_result[N-1:0];
          default: ;
        endcase
      end
      if (state_q == S_NX && idx_q != '0) begin
        idx_q <= idx_q - IW'(1);
      end
    end
  end

  assign bus.result   = res_q;
  assign bus.done     = (state_q == S_DN);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.mm_start = mm_start_q;
  assign bus.mm_a     = mm_a_q;
  assign bus.mm_b     = mm_b_q;
  assign bus.mm_m     = mm_m_q;
endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: directed checks of modexp_ctrl with a behavioural
// Montgomery core of variable latency and a plain modexp reference.
module tb_modexp_ctrl;
  localparam int N  = 1024;
  localparam int EW = 1024;
`ifdef MODEXP_LZ_SKIP_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   mm_cnt;
  int   lat_min;
  int   lat_max;
  bit   early_en;
  bit   core_busy;

  modexp_ctrl_if #(.N(N), .EW(EW)) bus ();

  modexp_ctrl #(.N(N), .EW(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h",
               tag, got[511:0], exp[511:0]);
    end
  endtask

  function automatic logic [N-1:0] mont(input logic [N-1:0] a,
                                        input logic [N-1:0] b,
                                        input logic [N-1:0] m);
    logic [N+1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] pow_ref(input logic [N-1:0] x,
                                           input logic [EW-1:0] e,
                                           input logic [N-1:0] m);
    logic [2*N-1:0] acc, xx, mm;
    mm  = {{N{1'b0}}, m};
    xx  = {{N{1'b0}}, x};
    acc = (2*N)'(1) % mm;
    for (int i = EW - 1; i >= 0; i--) begin
      acc = (acc * acc) % mm;
      if (e[i]) acc = (acc * xx) % mm;
    end
    return acc[N-1:0];
  endfunction

  function automatic logic [N-1:0] r_of(input logic [N-1:0] m);
    logic [N:0] v;
    v    = '0;
    v[N] = 1'b1;
    v    = v % {1'b0, m};
    return v[N-1:0];
  endfunction

  function automatic logic [N-1:0] r2_of(input logic [N-1:0] m,
                                         input logic [N-1:0] r);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, r} * {{N{1'b0}}, r};
    p = p % {{N{1'b0}}, m};
    return p[N-1:0];
  endfunction

  function automatic int exp_pulses(input logic [EW-1:0] e);
    int pop;
    int msb;
    pop = 0;
    msb = -1;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) begin
        pop++;
        msb = i;
      end
    end
    if (LZ) return (msb < 0) ? 2 : 2 + msb + pop;
    return 2 + EW + pop;
  endfunction

  // Behavioural core: captures operands on mm_start, answers after lat cycles.
  initial begin
    logic [N-1:0] ca, cb, cm, cr;
    int  lat;
    bit  stable, aborted;
    bus.mm_done   = 1'b0;
    bus.mm_result = '0;
    core_busy     = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.mm_start && !reset) begin
        ca = bus.mm_a;
        cb = bus.mm_b;
        cm = bus.mm_m;
        core_busy = 1'b1;
        mm_cnt++;
        stable  = 1'b1;
        aborted = 1'b0;
        lat = $urandom_range(lat_max, lat_min);
        if (early_en) begin
          bus.mm_done   = 1'b1;
          bus.mm_result = {1'b0, ~ca};
        end
        cr = mont(ca, cb, cm);
        for (int i = 0; i < lat; i++) begin
          @(posedge clk); #1;
          bus.mm_done = 1'b0;
          if (reset) aborted = 1'b1;
          if (!aborted && (bus.mm_a !== ca || bus.mm_b !== cb ||
                           bus.mm_m !== cm))
            stable = 1'b0;
        end
        bus.mm_done   = 1'b1;
        bus.mm_result = {1'($urandom), cr};
        @(posedge clk); #1;
        bus.mm_done = 1'b0;
        if (!aborted) chk("wait_stable", N'(stable), N'(1));
        core_busy = 1'b0;
      end
    end
  end

  task automatic wait_core_idle();
    for (int i = 0; i < 200 && core_busy; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue_start(input logic [N-1:0] x,
                             input logic [EW-1:0] e,
                             input logic [N-1:0] m);
    bus.in_x  = x;
    bus.in_e  = e;
    bus.in_m  = m;
    bus.in_r  = r_of(m);
    bus.in_r2 = r2_of(m, bus.in_r);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_x  = ~x;
    bus.in_e  = ~e;
    bus.in_m  = N'(7);
    bus.in_r  = '0;
    bus.in_r2 = '0;
  endtask

  task automatic run(input string tag,
                     input logic [N-1:0] x,
                     input logic [EW-1:0] e,
                     input logic [N-1:0] m,
                     input logic [N-1:0] exp_res,
                     input int exp_mm,
                     input bit poke);
    int cyc;
    int dones;
    bit seen;
    wait_core_idle();
    mm_cnt = 0;
    dones  = 0;
    seen   = 1'b0;
    cyc    = 0;
    issue_start(x, e, m);
    chk({tag, "_busy"}, N'(bus.busy), N'(1));
    while (!seen && cyc < 40000) begin
      if (bus.done) begin
        seen = 1'b1;
        dones++;
        chk({tag, "_res"}, bus.result, exp_res);
      end else begin
        if (poke && cyc == 20) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc++;
      end
    end
    chk({tag, "_no_timeout"}, N'(seen), N'(1));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk({tag, "_one_done"}, N'(dones), N'(1));
    chk({tag, "_hold"}, bus.result, exp_res);
    chk({tag, "_idle"}, N'(bus.busy), N'(0));
    chk({tag, "_mm_cnt"}, N'(mm_cnt), N'(exp_mm));
  endtask

  initial begin
    logic [N-1:0]  fx, fm;
    logic [EW-1:0] fe;
    int dones;
    n_chk     = 0;
    n_fail    = 0;
    mm_cnt    = 0;
    lat_min   = 1;
    lat_max   = 1;
    early_en  = 1'b0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.in_x  = '0;
    bus.in_e  = '0;
    bus.in_m  = '0;
    bus.in_r  = '0;
    bus.in_r2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", bus.result, N'(0));
    chk("rst_done", N'(bus.done), N'(0));
    chk("rst_busy", N'(bus.busy), N'(0));
    chk("rst_mm_start", N'(bus.mm_start), N'(0));
    chk("rst_mm_m", bus.mm_m, N'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    early_en = 1'b1;
    run("e5", N'(2), EW'(5), N'(13), N'(6), LZ ? 6 : 1028, 1'b0);
    early_en = 1'b0;
    run("e0", N'(7), EW'(0), N'(13), N'(1), LZ ? 2 : 1026, 1'b0);
    run("e1", N'(2), EW'(1), N'(13), N'(2), LZ ? 3 : 1027, 1'b0);
    run("x0", N'(0), EW'(3), N'(13), N'(0), LZ ? 5 : 1028, 1'b0);
    lat_max = 2;
    run("poke", N'(7), EW'(3), N'(13), N'(5), LZ ? 5 : 1028, 1'b1);

    lat_max = 5;
    for (int i = 0; i < N / 32; i++) begin
      fm[i*32 +: 32] = $urandom;
      fx[i*32 +: 32] = $urandom;
      fe[i*32 +: 32] = $urandom;
    end
    fm[N-1] = 1'b1;
    fm[0]   = 1'b1;
    fx[N-1] = 1'b0;
    run("full", fx, fe, fm, pow_ref(fx, fe, fm), exp_pulses(fe), 1'b0);

    lat_min = 3;
    lat_max = 3;
    wait_core_idle();
    mm_cnt = 0;
    issue_start(N'(2), EW'(5), N'(13));
    for (int i = 0; i < 200 && mm_cnt < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_sqr", N'(mm_cnt), N'(2));
    reset = 1'b1;
    #2;
    chk("mid_result", bus.result, N'(0));
    chk("mid_done", N'(bus.done), N'(0));
    chk("mid_busy", N'(bus.busy), N'(0));
    chk("mid_mm_start", N'(bus.mm_start), N'(0));
    chk("mid_mm_a", bus.mm_a, N'(0));
    chk("mid_mm_b", bus.mm_b, N'(0));
    chk("mid_mm_m", bus.mm_m, N'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy || bus.mm_start) dones++;
    end
    chk("stale_ignored", N'(dones), N'(0));
    lat_min = 1;
    lat_max = 2;
    run("post_rst", N'(2), EW'(5), N'(13), N'(6), LZ ? 6 : 1028, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
